// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the layout of the
// 4-bit condition-flag vector produced by the add/subtract stage.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  // Flag vector bit positions ({V,N,Z,C} when read MSB first)
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int FLG_W = 4;

  typedef logic [FLG_W-1:0] flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational C/Z/N/V generation for an adder result.
//  a, b_cond : adder operands (b_cond already conditioned to B or ~B)
//  r         : truncated WIDTH-bit sum
//  c         : carry out of bit WIDTH-1
//  flags     : packed {V,N,Z,C} vector
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_cond,
  input  logic [WIDTH-1:0] r,
  input  logic             c,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;

  // Only the sign bits of the operands matter for overflow
  logic unused_lo;
  assign unused_lo = ^{a[MSB-1:0], b_cond[MSB-1:0]};

  always_comb begin
    flags        = '0;
    flags[FLG_C] = c;
    flags[FLG_Z] = ~|r;
    flags[FLG_N] = r[MSB];
    // Overflow: like-signed operands producing a result of the other sign.
    // Subtract is covered because b_cond is already ~B with carry-in 1.
    flags[FLG_V] = (a[MSB] == b_cond[MSB]) & (r[MSB] != a[MSB]);
  end

endmodule

// File: rtl/alu_addsub_stage.sv
// Registered add/subtract stage, two-deep valid/ready pipeline.
//  S1 captures {a, b_cond, invert}; S2 captures {result, flags} computed
//  from S1, so flags always belong to the result they travel with.
//  Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream handshake
//   a, b_cond, invert     operands; invert doubles as carry-in (1 = subtract)
//   out_valid/out_ready   downstream handshake
//   result, flag_c/z/n/v  registered sum and condition flags
module alu_addsub_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_cond,
  input  logic             invert,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_inv;
  logic [WIDTH-1:0] s2_result;
  flags_t           s2_flags;

  logic             adv1, adv2;
  logic [WIDTH:0]   sum;
  flags_t           flags_nxt;

  // A stage may load when it is empty or its contents move on this edge;
  // this lets both stages shift together with no bubble when full.
  assign adv2     = !s2_valid | out_ready;
  assign adv1     = !s1_valid | adv2;
  assign in_ready = adv1 & rst_n;

  assign sum = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_inv};

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .a      (s1_a),
    .b_cond (s1_b),
    .r      (sum[WIDTH-1:0]),
    .c      (sum[WIDTH]),
    .flags  (flags_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_inv   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      s1_a     <= a;
      s1_b     <= b_cond;
      s1_inv   <= invert;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (adv2) begin
      s2_valid  <= s1_valid;
      s2_result <= sum[WIDTH-1:0];
      s2_flags  <= flags_nxt;
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign flag_c    = s2_flags[FLG_C];
  assign flag_z    = s2_flags[FLG_Z];
  assign flag_n    = s2_flags[FLG_N];
  assign flag_v    = s2_flags[FLG_V];

endmodule

// File: tb/tb_alu_addsub_stage.sv
module tb_alu_addsub_stage;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b_cond = '0;
  logic         invert = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         flag_c, flag_z, flag_n, flag_v;

  alu_addsub_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b_cond    (b_cond),
    .invert    (invert),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  logic [3:0] flags;
  assign flags = {flag_v, flag_n, flag_z, flag_c};

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] f;   // {V,N,Z,C}
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int n_out = 0, n_acc = 0, n_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic c, z, n, v);
    exp_t e;
    e.r = r;
    e.f = {v, n, z, c};
    return e;
  endfunction

  // Reference: unsigned sum for C, signed integer sum range for V
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int u, s;
    exp_t e;
    u = int'(x) + int'(y) + int'(ci);
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    e.r = u[7:0];
    e.f = {(s > 127) || (s < -128), u[7], (u[7:0] == 8'h00), (u > 255)};
    return e;
  endfunction

  // Monitor: compare every transfer against the scoreboard, and check that
  // a stalled output stays bit-stable.
  logic        st_prev = 1'b0;
  logic [11:0] st_val = '0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      st_prev = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (st_prev) chk("hold_stable", {20'd0, result, flags}, {20'd0, st_val});
        st_prev = 1'b1;
        st_val  = {result, flags};
      end else begin
        st_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {24'd0, result}, 32'hFFFF_FFFF);
        end else begin
          mon_e = q.pop_front();
          chk("result", {24'd0, result}, {24'd0, mon_e.r});
          chk("flags_vnzc", {28'd0, flags}, {28'd0, mon_e.f});
        end
        n_out++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic ci, input exp_t e);
    in_valid = 1'b1;
    a        = x;
    b_cond   = y;
    invert   = ci;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        n_acc++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      n_stall++;
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [7:0] x, input logic [7:0] y, input logic ci);
    send(x, y, ci, model(x, y, ci));
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_empty", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int o0, a0, s0, cnt;
  logic [7:0] ra, rb;
  logic       ri;

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Add, with latency check on an empty pipeline
    send(8'h05, 8'h03, 1'b0, mk(8'h08, 0, 0, 0, 0));
    chk("lat_s1_only", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_two_cycles", {31'd0, out_valid}, 32'd1);
    drain();

    // Hand-computed corner vectors
    send(8'h05, 8'hFA, 1'b1, mk(8'h00, 1, 1, 0, 0));  // 5 - 5
    send(8'h7F, 8'h01, 1'b0, mk(8'h80, 0, 0, 1, 1));  // signed overflow
    send(8'hFF, 8'h01, 1'b0, mk(8'h00, 1, 1, 0, 0));  // unsigned wrap
    send(8'h80, 8'hFE, 1'b1, mk(8'h7F, 1, 0, 0, 1));  // -128 - 1
    send(8'h00, 8'hFE, 1'b1, mk(8'hFF, 0, 0, 1, 0));  // 0 - 1, borrow
    drain();

    // Back-pressure: 4 inputs, output held off for 5 cycles
    out_ready = 1'b0;
    a0 = n_acc;
    o0 = n_out;
    fork
      begin
        sendm(8'h10, 8'h20, 1'b0);
        sendm(8'h40, 8'hBF, 1'b1);
        sendm(8'hC0, 8'hC0, 1'b0);
        sendm(8'h33, 8'hCC, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_accepts", n_acc - a0, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_out_count", n_out - o0, 32'd4);

    // Full throughput: 16 back-to-back vectors
    s0 = n_stall;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          ri = 1'($urandom);
          sendm(ra, rb, ri);
        end
      end
      begin
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        if (out_valid) cnt = 1;
        repeat (15) begin
          @(negedge clk);
          if (out_valid) cnt++;
        end
        chk("stream_consecutive", cnt, 32'd16);
      end
    join
    chk("stream_no_stall", n_stall - s0, 32'd0);
    drain();

    // Async reset mid-cycle with both stages full
    out_ready = 1'b0;
    sendm(8'h11, 8'h22, 1'b0);
    sendm(8'h7F, 8'h7F, 1'b0);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", {24'd0, result}, 32'd0);
    chk("mid_rst_flags", {28'd0, flags}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    o0 = n_out;
    send(8'h80, 8'h80, 1'b0, mk(8'h00, 1, 1, 0, 1));
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_out_count", n_out - o0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
